// File: rtl/irq_controller_if.sv
// Signal bundle between irq_controller and its neighbours (timer irq/clear/enable,
// retire stream, PC-select redirect and status outputs).
interface irq_controller_if;
    logic        irq_in;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [31:0] pc_next;
    logic        clear_irq;
    logic        timer_enable;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc_out;
    logic        kernel_mode;
    logic [1:0]  cause_out;

    modport master (
        output irq_in, instr_valid, opcode, pc_next,
        input  clear_irq, timer_enable, redirect, redirect_pc,
               epc_out, kernel_mode, cause_out
    );

    modport slave (
        input  irq_in, instr_valid, opcode, pc_next,
        output clear_irq, timer_enable, redirect, redirect_pc,
               epc_out, kernel_mode, cause_out
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt responder: timer irq entry to the kernel vector, RETI return to epc.
// Optional macro INT_SYSCALL_EN adds the OP_SYSCALL software trap.
module irq_controller #(
    parameter logic [31:0] VECTOR_ADDR = 32'd4,
    parameter logic [5:0]  OP_RETI     = 6'b100111,
    parameter logic [5:0]  OP_SYSCALL  = 6'b101001
) (
    input logic              clock,
    input logic              reset,
    irq_controller_if.slave  bus
);
    typedef enum logic {USER, KERNEL} state_t;

    state_t      state, state_d;
    logic [31:0] epc, epc_d;
    logic [1:0]  cause, cause_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        clear_q, clear_d;
    logic        timer_enable_q, kernel_mode_q;
    logic        syscall_hit;

`ifdef INT_SYSCALL_EN
    assign syscall_hit = (bus.opcode == OP_SYSCALL);
`else
    assign syscall_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= USER;
            epc            <= '0;
            cause          <= '0;
            redirect_q     <= 1'b0;
            redirect_pc_q  <= '0;
            clear_q        <= 1'b0;
            timer_enable_q <= 1'b1;
            kernel_mode_q  <= 1'b0;
        end else begin
            state          <= state_d;
            epc            <= epc_d;
            cause          <= cause_d;
            redirect_q     <= redirect_d;
            redirect_pc_q  <= redirect_pc_d;
            clear_q        <= clear_d;
            timer_enable_q <= (state_d == USER);
            kernel_mode_q  <= (state_d == KERNEL);
        end
    end

    always_comb begin
        state_d       = state;
        epc_d         = epc;
        cause_d       = cause;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        clear_d       = 1'b0;
        case (state)
            USER: begin
                // Syscall outranks a simultaneous timer request; the irq stays pending.
                if (bus.instr_valid && (syscall_hit || bus.irq_in)) begin
                    state_d       = KERNEL;
                    epc_d         = bus.pc_next;
                    cause_d       = syscall_hit ? 2'd2 : 2'd1;
                    redirect_d    = 1'b1;
                    redirect_pc_d = VECTOR_ADDR;
                    clear_d       = ~syscall_hit;
                end
            end
            KERNEL: begin
                if (bus.instr_valid && bus.opcode == OP_RETI) begin
                    state_d       = USER;
                    cause_d       = 2'd0;
                    redirect_d    = 1'b1;
                    redirect_pc_d = epc;
                end
            end
            default: state_d = USER;
        endcase
    end

    assign bus.clear_irq    = clear_q;
    assign bus.timer_enable = timer_enable_q;
    assign bus.redirect     = redirect_q;
    assign bus.redirect_pc  = redirect_pc_q;
    assign bus.epc_out      = epc;
    assign bus.kernel_mode  = kernel_mode_q;
    assign bus.cause_out    = cause;
endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios then random retire traffic
// checked against a behavioural model of the interrupt rules.
module tb_irq_controller;
    localparam logic [5:0]  OP_RETI    = 6'b100111;
    localparam logic [5:0]  OP_SYSCALL = 6'b101001;
    localparam logic [5:0]  OP_NOP     = 6'b000000;
    localparam logic [31:0] VEC        = 32'd4;
`ifdef INT_SYSCALL_EN
    localparam bit SYS_EN = 1'b1;
`else
    localparam bit SYS_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    irq_controller_if bus ();

    irq_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Model: handler status plus expected values visible after the next edge.
    bit          m_kernel;
    logic [31:0] m_epc;
    logic [1:0]  m_cause;
    bit          e_redirect, e_clear;
    logic [31:0] e_rpc;

    task automatic model_reset();
        m_kernel = 0; m_epc = '0; m_cause = '0;
        e_redirect = 0; e_clear = 0; e_rpc = '0;
    endtask

    task automatic model_step(input bit irq, input bit iv, input logic [5:0] op,
                              input logic [31:0] pc);
        e_redirect = 0;
        e_clear    = 0;
        if (!m_kernel) begin
            if (iv && SYS_EN && op == OP_SYSCALL) begin
                m_kernel = 1; m_epc = pc; m_cause = 2;
                e_redirect = 1; e_rpc = VEC;
            end else if (iv && irq) begin
                m_kernel = 1; m_epc = pc; m_cause = 1;
                e_redirect = 1; e_rpc = VEC; e_clear = 1;
            end
        end else if (iv && op == OP_RETI) begin
            m_kernel = 0; m_cause = 0;
            e_redirect = 1; e_rpc = m_epc;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".redirect"},     32'(bus.redirect),     32'(e_redirect));
        chk({tag, ".clear_irq"},    32'(bus.clear_irq),    32'(e_clear));
        chk({tag, ".kernel_mode"},  32'(bus.kernel_mode),  32'(m_kernel));
        chk({tag, ".timer_enable"}, 32'(bus.timer_enable), 32'(!m_kernel));
        chk({tag, ".epc_out"},      bus.epc_out,           m_epc);
        chk({tag, ".cause_out"},    32'(bus.cause_out),    32'(m_cause));
        if (e_redirect) chk({tag, ".redirect_pc"}, bus.redirect_pc, e_rpc);
    endtask

    task automatic cycle(input string tag, input bit irq, input bit iv,
                         input logic [5:0] op, input logic [31:0] pc);
        bus.irq_in      = irq;
        bus.instr_valid = iv;
        bus.opcode      = op;
        bus.pc_next     = pc;
        model_step(irq, iv, op, pc);
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.irq_in = 0; bus.instr_valid = 0; bus.opcode = '0; bus.pc_next = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        chk("reset.redirect_pc", bus.redirect_pc, 32'd0);
        reset = 0;

        for (int i = 0; i < 3; i++) cycle("idle", 0, 0, OP_NOP, 32'h0);

        cycle("entry40", 1, 1, OP_NOP, 32'h40);
        cycle("entry40+1", 1, 0, OP_NOP, 32'h0);
        cycle("kern_idle", 0, 0, OP_NOP, 32'h0);
        cycle("reti40", 0, 1, OP_RETI, 32'h0);

        for (int i = 0; i < 3; i++) cycle("irq_wait", 1, 0, OP_NOP, 32'h0);
        cycle("entry80", 1, 1, OP_NOP, 32'h80);
        cycle("kern_irq", 1, 1, OP_NOP, 32'h84);
        cycle("kern_irq2", 1, 1, OP_SYSCALL, 32'h88);
        cycle("reti80", 1, 1, OP_RETI, 32'h0);
        cycle("pend_take", 1, 1, OP_NOP, 32'hC0);
        cycle("reti_b2b", 0, 1, OP_RETI, 32'h0);
        cycle("reti_user", 0, 1, OP_RETI, 32'h200);

        cycle("sys100", 1, 1, OP_SYSCALL, 32'h100);
        cycle("sys_reti", 1, 1, OP_RETI, 32'h0);
        cycle("sys_after", 1, 1, OP_NOP, 32'h104);
        cycle("sys_after_reti", 0, 1, OP_RETI, 32'h0);
        cycle("sys_alone", 0, 1, OP_SYSCALL, 32'h300);
        cycle("sys_alone_reti", 0, 1, OP_RETI, 32'h0);

        cycle("pre_rst", 1, 1, OP_NOP, 32'h500);
        #2;
        reset = 1;
        #1;
        model_reset();
        check_all("rst_mid");
        @(negedge clock);
        reset = 0;
        cycle("post_rst", 0, 0, OP_NOP, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [5:0]  op;
            int unsigned sel;
            sel = $urandom_range(0, 3);
            op  = (sel == 0) ? OP_RETI : (sel == 1) ? OP_SYSCALL : 6'($urandom);
            cycle("rand", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  op, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
